// File: rtl/regfile_wb_arbiter.sv
// Register file write-port arbiter: round-robin between ALU (A) and LSU (B) writeback,
// x0 suppression, stall, contention counter. Define REGFILE_WB_FWD_EN for write forwarding.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter bit          PRIO_RESET = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  input  logic              wb_stall,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              fwd1_hit,
  output logic [DATA_W-1:0] fwd1_data,
  output logic              fwd2_hit,
  output logic [DATA_W-1:0] fwd2_data,
  output logic [15:0]       contend_cnt
);

  // 0: A preferred on contention, 1: B preferred
  logic ptr_q;

  logic              contend;
  logic              xfer;
  logic [ADDR_W-1:0] xfer_addr;
  logic [DATA_W-1:0] xfer_data;

  assign contend = a_valid && b_valid && !wb_stall;

  always_comb begin
    a_ready   = 1'b0;
    b_ready   = 1'b0;
    xfer_addr = a_addr;
    xfer_data = a_data;
    if (rst_n && !wb_stall) begin
      a_ready = a_valid && (!b_valid || !ptr_q);
      b_ready = b_valid && (!a_valid || ptr_q);
    end
    if (b_ready) begin
      xfer_addr = b_addr;
      xfer_data = b_data;
    end
  end

  assign xfer = a_ready || b_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= PRIO_RESET;
      wb_en       <= 1'b0;
      wb_addr     <= '0;
      wb_data     <= '0;
      contend_cnt <= '0;
    end else begin
      if (contend) begin
        ptr_q <= ~ptr_q;
        if (contend_cnt != 16'hFFFF) begin
          contend_cnt <= contend_cnt + 16'd1;
        end
      end
      wb_en <= xfer && (xfer_addr != '0);
      if (xfer) begin
        wb_addr <= xfer_addr;
        wb_data <= xfer_data;
      end
    end
  end

`ifdef REGFILE_WB_FWD_EN
  // Aligns with the register file's registered read: a read launched alongside a write
  // returns stale data one cycle later, and this flag replaces it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd1_hit  <= 1'b0;
      fwd1_data <= '0;
      fwd2_hit  <= 1'b0;
      fwd2_data <= '0;
    end else begin
      fwd1_hit  <= wb_en && (wb_addr == rs1_addr) && (rs1_addr != '0);
      fwd1_data <= wb_data;
      fwd2_hit  <= wb_en && (wb_addr == rs2_addr) && (rs2_addr != '0);
      fwd2_data <= wb_data;
    end
  end
`else
  logic unused_rs;
  assign unused_rs = ^{rs1_addr, rs2_addr};
  assign fwd1_hit  = 1'b0;
  assign fwd1_data = '0;
  assign fwd2_hit  = 1'b0;
  assign fwd2_data = '0;
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Write-port controller for the 32x32 register file, which has one synchronous write port. Two writeback requesters share that port: A is the ALU/execute path and B is the load/LSU path. The block arbitrates between them with valid/ready and round-robin fairness, and drives registered enable/address/data to the register file. It also suppresses writes to x0 and supports a pipeline stall.

Parameters:
DATA_W, 32, writeback data width
ADDR_W, 5, register address width
PRIO_RESET, 0, round-robin pointer value after reset (0 = A preferred, 1 = B preferred)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
a_valid  in  1  requester A holds a write
a_addr  in  ADDR_W  A destination register
a_data  in  DATA_W  A write data
a_ready  out  1  A transfer accepted this cycle
b_valid  in  1  requester B holds a write
b_addr  in  ADDR_W  B destination register
b_data  in  DATA_W  B write data
b_ready  out  1  B transfer accepted this cycle
wb_stall  in  1  pipeline stall; blocks all grants
rs1_addr  in  ADDR_W  read address 1 presented to the register file this cycle (forwarding only)
rs2_addr  in  ADDR_W  read address 2 presented to the register file this cycle (forwarding only)
wb_en  out  1  register file write enable
wb_addr  out  ADDR_W  register file write address
wb_data  out  DATA_W  register file write data
fwd1_hit  out  1  rs1 read data must be replaced by fwd1_data
fwd1_data  out  DATA_W  forwarded value for rs1
fwd2_hit  out  1  rs2 read data must be replaced by fwd2_data
fwd2_data  out  DATA_W  forwarded value for rs2
contend_cnt  out  16  count of cycles in which both requesters were valid and not stalled

Behaviour:
- Reset (rst_n low, asynchronous):
  - wb_en=0, wb_addr=0, wb_data=0.
  - fwd*_hit=0, fwd*_data=0, contend_cnt=0.
  - Round-robin pointer = PRIO_RESET.
  - a_ready and b_ready forced to 0 while rst_n is low.
- Grant is combinational within the cycle; at most one of a_ready/b_ready is high.
- wb_stall=1: a_ready=b_ready=0, and wb_en goes to 0 on the next edge.
- Exactly one requester valid: that requester is granted.
- Both valid: the requester selected by the pointer is granted. The pointer then flips to the other requester on that edge.
- The pointer is unchanged when there is no contention.
- Requesters hold addr/data stable while valid and not ready. Dropping valid before the grant is allowed and results in no write.
- Transfer occurs on valid and ready at the rising edge.
- Latency: one cycle. On the edge after a transfer, wb_addr and wb_data take the granted values and wb_en=1.
- x0 suppression: a transfer with addr==0 is accepted (ready asserted). wb_en=0; wb_addr/wb_data still latch.
- wb_en returns to 0 on any edge with no transfer; wb_addr/wb_data hold their last values.
- Back-to-back transfers are allowed every cycle. There is no bubble when switching requesters.
- contend_cnt increments when a_valid and b_valid are both high and wb_stall=0. It saturates at 0xFFFF.
- Reset mid-transfer: the in-flight registered write is discarded (wb_en=0 immediately). No requester observes ready.

Optional Feature:
Macro REGFILE_WB_FWD_EN.
- Defined: on each edge, fwdN_hit <= wb_en && (wb_addr == rsN_addr) && (rsN_addr != 0), and fwdN_data <= wb_data.
  - Timing aligns with the register file's registered read. A read launched in the same cycle as a write returns old data, and the hit flag corrects it.
  - rs1 and rs2 are evaluated independently; both may hit.
- Undefined: fwd1_hit=fwd2_hit=0 and fwd1_data=fwd2_data=0 constantly. rs1_addr/rs2_addr are ignored.

Test Plan:
- Single requester: a_valid=1, a_addr=5, a_data=0xDEADBEEF for one cycle -> a_ready=1 that cycle; next cycle wb_en=1, wb_addr=5, wb_data=0xDEADBEEF; the cycle after, wb_en=0.
- Contention: a and b both valid for 4 cycles after reset (PRIO_RESET=0) -> grant sequence A,B,A,B; wb_addr follows the same sequence; contend_cnt=4.
- x0 write: b_valid=1, b_addr=0, b_data=0x1234 -> b_ready=1; next cycle wb_en=0.
- Stall: both valid, wb_stall=1 for 3 cycles -> both ready=0, wb_en=0, contend_cnt unchanged. Release stall -> pointer-selected requester granted first.
- Async reset mid-stream: deassert rst_n between edges while wb_en=1 -> wb_en=0 and the ready signals drop immediately. After release, the first grant under contention goes to PRIO_RESET.
- REGFILE_WB_FWD_EN: write x7=0xA5A5A5A5 while rs1_addr=7, rs2_addr=7 -> next cycle fwd1_hit=fwd2_hit=1, fwd1_data=fwd2_data=0xA5A5A5A5. A write to x0 with rs1_addr=0 -> fwd1_hit=0.
